// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline freeze controller: memory-access FSM
// state encoding and the default SRAM latency.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  localparam int unsigned MEM_LATENCY_DEFAULT = 6;

endpackage

// File: rtl/mem_access_timer.sv
// Down-counter for the SRAM wait: loads a start value, decrements on request
// and flags the final access cycle (count == 1).
module mem_access_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  // counter register: load has priority over decrement, never wraps below 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last = (cnt_r == CNT_ONE);

endmodule

// File: rtl/pipeline_freeze_controller.sv
// Pipeline hazard/flush control plus a multi-cycle SRAM access FSM that
// freezes the whole pipeline for MEM_LATENCY cycles per load/store.
module pipeline_freeze_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEFAULT,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_Detected,
  input  logic        branch_taken,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  output logic        pc_freeze,
  output logic        if_id_freeze,
  output logic        if_id_flush,
  output logic        id_exe_flush,
  output logic        exe_mem_freeze,
  output logic        mem_wb_freeze,
  output logic        mem_start,
  output logic        mem_busy,
  output logic [15:0] stall_count
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LATENCY - 1);

  mem_state_e  state_r;
  mem_state_e  state_next_s;
  logic        mem_req_s;
  logic        mem_freeze_s;
  logic        mem_start_s;
  logic        timer_load_s;
  logic        timer_dec_s;
  logic        timer_last_s;
  logic [15:0] stall_cnt_r;

  assign mem_req_s = mem_r_en | mem_w_en;

  mem_access_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load_s),
    .load_val (LOAD_VAL),
    .dec      (timer_dec_s),
    .last     (timer_last_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next state and access-phase decode; DONE is the single cycle the pipeline advances
  always_comb begin
    state_next_s = state_r;
    mem_freeze_s = 1'b0;
    mem_start_s  = 1'b0;
    timer_load_s = 1'b0;
    timer_dec_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_req_s) begin
          mem_freeze_s = 1'b1;
          mem_start_s  = 1'b1;
          timer_load_s = 1'b1;
          state_next_s = ST_ACCESS;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        mem_freeze_s = 1'b1;
        timer_dec_s  = 1'b1;
        if (timer_last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_ACCESS;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // freeze/flush priority: reset, memory freeze, taken branch, load-use hazard
  always_comb begin
    pc_freeze      = 1'b0;
    if_id_freeze   = 1'b0;
    if_id_flush    = 1'b0;
    id_exe_flush   = 1'b0;
    exe_mem_freeze = 1'b0;
    mem_wb_freeze  = 1'b0;
    mem_start      = 1'b0;
    mem_busy       = 1'b0;
    if (!rst) begin
      pc_freeze = 1'b0;
    end else if (mem_freeze_s) begin
      pc_freeze      = 1'b1;
      if_id_freeze   = 1'b1;
      exe_mem_freeze = 1'b1;
      mem_wb_freeze  = 1'b1;
      mem_start      = mem_start_s;
      mem_busy       = 1'b1;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
    end else if (hazard_Detected) begin
      pc_freeze    = 1'b1;
      if_id_freeze = 1'b1;
      id_exe_flush = 1'b1;
    end else begin
      pc_freeze = 1'b0;
    end
  end

  // saturating count of memory-freeze cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_r <= 16'd0;
    end else if (mem_freeze_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_count = rst ? stall_cnt_r : 16'd0;

endmodule

// File: tb/tb_pipeline_freeze_controller.sv
// Self-checking bench for pipeline_freeze_controller: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_pipeline_freeze_controller;

  localparam int L = 6;

  logic        clk = 1'b0;
  logic        rst, hazard_Detected, branch_taken, mem_r_en, mem_w_en;
  logic        pc_freeze, if_id_freeze, if_id_flush, id_exe_flush;
  logic        exe_mem_freeze, mem_wb_freeze, mem_start, mem_busy;
  logic [15:0] stall_count;
  logic [23:0] obs;
  logic [23:0] exp_v;

  int vectors = 0;
  int miscompares = 0;

  // model: freeze cycles still owed by the current access, DONE-cycle flag, stall total
  int m_left = 0;
  bit m_done = 1'b0;
  int m_stalls = 0;

  pipeline_freeze_controller #(.MEM_LATENCY(L), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .hazard_Detected(hazard_Detected), .branch_taken(branch_taken),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .pc_freeze(pc_freeze),
    .if_id_freeze(if_id_freeze), .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
    .exe_mem_freeze(exe_mem_freeze), .mem_wb_freeze(mem_wb_freeze), .mem_start(mem_start),
    .mem_busy(mem_busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  assign obs = {pc_freeze, if_id_freeze, if_id_flush, id_exe_flush,
                exe_mem_freeze, mem_wb_freeze, mem_start, mem_busy, stall_count};

  function automatic logic [23:0] model_exp();
    logic req, fr, st;
    logic [7:0] o;
    int s;
    req = mem_r_en | mem_w_en;
    fr  = (m_left > 0) || (!m_done && req);
    st  = (m_left == 0) && !m_done && req;
    s   = m_stalls;
    if (!rst) return 24'd0;
    if (fr)                o = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, st, 1'b1};
    else if (branch_taken) o = 8'b0011_0000;
    else if (hazard_Detected) o = 8'b1101_0000;
    else                   o = 8'b0000_0000;
    return {o, s[15:0]};
  endfunction

  task automatic model_tick();
    logic req;
    req = mem_r_en | mem_w_en;
    if (!rst) begin
      m_left = 0; m_done = 1'b0; m_stalls = 0;
    end else begin
      if (((m_left > 0) || (!m_done && req)) && (m_stalls < 65535)) m_stalls++;
      if (m_left > 0) begin
        m_left--;
        m_done = (m_left == 0);
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (req) begin
        m_left = L - 1;
      end
    end
  endtask

  task automatic drive(input logic r, input logic h, input logic b, input logic rd, input logic wr);
    @(negedge clk);
    rst = r; hazard_Detected = h; branch_taken = b; mem_r_en = rd; mem_w_en = wr;
    #1;
    exp_v = model_exp();
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      vectors++;
      if (obs !== 24'd0) begin
        miscompares++;
        $display("FAIL reset: got %h expected %h", obs, 24'd0);
      end
      tick();
    end
  endtask

  task automatic test_load_latency();
    int starts = 0;
    int frz = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 1'b0, 1'b0, c == 0, 1'b0);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL load_c%0d: got %h expected %h", c, obs, exp_v);
      end
      starts += int'(mem_start);
      frz += int'(pc_freeze & if_id_freeze & exe_mem_freeze & mem_wb_freeze);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (starts != 1 || frz != 6 || stall_count !== 16'd6) begin
      miscompares++;
      $display("FAIL load_totals: got starts=%0d freezes=%0d stalls=%0d expected 1/6/6",
               starts, frz, stall_count);
    end
    tick();
  endtask

  task automatic test_branch_hazard();
    logic [4:0] pat [4] = '{5'b11100, 5'b10100, 5'b11000, 5'b10000};
    logic [4:0] p;
    for (int i = 0; i < 4; i++) begin
      p = pat[i];
      drive(p[4], p[3], p[2], p[1], p[0]);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL branch_hazard_%0d: got %h expected %h", i, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_branch_during_access();
    int flushes = 0;
    int flush_cyc = -1;
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, c == 0);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL branch_access_c%0d: got %h expected %h", c, obs, exp_v);
      end
      if (if_id_flush) begin
        flushes++;
        flush_cyc = c;
      end
      tick();
    end
    vectors++;
    if (flushes != 1 || flush_cyc != 6) begin
      miscompares++;
      $display("FAIL branch_access_flush: got count=%0d cycle=%0d expected 1/6", flushes, flush_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int starts [$];
    int base;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    base = m_stalls;
    for (int c = 0; c < 19; c++) begin
      drive(c != 17, 1'b0, 1'b0, 1'b0, (c <= 7) || (c == 14));
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL b2b_c%0d: got %h expected %h", c, obs, exp_v);
      end
      if (mem_start) starts.push_back(c);
      if (c == 14) begin
        vectors++;
        if (stall_count !== 16'(base + 12)) begin
          miscompares++;
          $display("FAIL b2b_stalls: got %0d expected %0d", stall_count, base + 12);
        end
      end
      if (c == 17 || c == 18) begin
        vectors++;
        if (obs !== 24'd0) begin
          miscompares++;
          $display("FAIL b2b_reset_c%0d: got %h expected %h", c, obs, 24'd0);
        end
      end
      tick();
    end
    vectors++;
    if (starts.size() != 3 || starts[0] != 0 || starts[1] != 7 || starts[2] != 14) begin
      miscompares++;
      $display("FAIL b2b_starts: got %0d pulses expected 3 at cycles 0,7,14", starts.size());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL random_c%0d: got %h expected %h", c, obs, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; hazard_Detected = 1'b0; branch_taken = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    test_reset();
    test_load_latency();
    test_branch_hazard();
    test_branch_during_access();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_freeze_controller.md
PIPELINE_FREEZE_CONTROLLER -- requirements
Module: pipeline_freeze_controller

Interface
REQ-001 Parameter MEM_LATENCY, default 6, SHALL set the SRAM access time in clk cycles (legal range 2..15).
REQ-002 Parameter CNT_W, default 4, SHALL set the wait-counter width; MEM_LATENCY SHALL fit in CNT_W bits.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-low.
REQ-005 hazard_Detected  in  1  load-use or branch-operand hazard from the ID-stage hazard unit.
REQ-006 branch_taken  in  1  resolved taken branch in EXE.
REQ-007 mem_r_en  in  1  MEM-stage load request.
REQ-008 mem_w_en  in  1  MEM-stage store request.
REQ-009 pc_freeze  out  1  hold PC.
REQ-010 if_id_freeze  out  1  hold IF/ID register.
REQ-011 if_id_flush  out  1  clear IF/ID register to NOP.
REQ-012 id_exe_flush  out  1  load bubble into ID/EXE register.
REQ-013 exe_mem_freeze  out  1  hold EXE/MEM register.
REQ-014 mem_wb_freeze  out  1  hold MEM/WB register.
REQ-015 mem_start  out  1  one-cycle SRAM access start strobe.
REQ-016 mem_busy  out  1  SRAM access in progress.
REQ-017 stall_count  out  16  count of memory-freeze cycles since reset.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS and DONE.
REQ-019 IDLE with (mem_r_en | mem_w_en) = 1 SHALL assert mem_start for that cycle, load the counter with MEM_LATENCY-1 and move to ACCESS.
REQ-020 ACCESS SHALL decrement the counter each cycle and move to DONE on the cycle the counter equals 1.
REQ-021 DONE SHALL last exactly one cycle, ignore mem_r_en/mem_w_en and return to IDLE.
REQ-022 mem_freeze = (IDLE & request) | ACCESS; total freeze SHALL be exactly MEM_LATENCY cycles per access, and the pipeline advances in the DONE cycle.
REQ-023 mem_busy SHALL equal mem_freeze.
REQ-024 While mem_freeze = 1: pc_freeze, if_id_freeze, exe_mem_freeze and mem_wb_freeze SHALL be 1; if_id_flush and id_exe_flush SHALL be 0 regardless of branch_taken or hazard_Detected.
REQ-025 Else, if branch_taken = 1: if_id_flush = id_exe_flush = 1; all freezes = 0; hazard_Detected SHALL be ignored.
REQ-026 Else, if hazard_Detected = 1: pc_freeze = if_id_freeze = id_exe_flush = 1; other outputs 0.
REQ-027 Else, all freeze/flush outputs SHALL be 0.
REQ-028 Freeze/flush outputs and mem_start SHALL be combinational from state and inputs, with no added latency.
REQ-029 stall_count SHALL increment by 1 on every cycle with mem_freeze = 1 and saturate at 0xFFFF.
REQ-030 Back-to-back memory instructions: a request seen in IDLE one cycle after DONE SHALL start a new access.
REQ-031 Simultaneous mem_r_en and mem_w_en SHALL be treated as a single access.

Reset
REQ-032 While rst = 0 at a clock edge, state SHALL become IDLE, counter 0 and stall_count 0.
REQ-033 While rst = 0, all outputs SHALL be 0, including during an ACCESS in progress (reset mid-access abandons the access).

Structure
REQ-034 Package pipeline_ctrl_pkg SHALL hold the FSM state encoding and the default MEM_LATENCY constant.
REQ-035 The wait counter SHALL be one sub-module, mem_access_timer (load, decrement, last-cycle flag).

Verification
REQ-036 Load in MEM with MEM_LATENCY=6 -> mem_start is high for 1 cycle, all four freezes are high for 6 cycles, DONE occurs on cycle 7, and stall_count = 6.
REQ-037 Branch_taken with no memory op -> if_id_flush = id_exe_flush = 1 for 1 cycle and pc_freeze = 0, even with hazard_Detected = 1.
REQ-038 hazard_Detected = 1 for 1 cycle -> pc_freeze = if_id_freeze = id_exe_flush = 1 for that cycle only.
REQ-039 Branch_taken asserted during ACCESS -> no flush during the freeze; flush asserts in the DONE cycle.
REQ-040 Two consecutive stores -> two mem_start pulses 7 cycles apart and stall_count = 12; rst = 0 on the 3rd ACCESS cycle -> all outputs 0 and IDLE next cycle.
